// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Synchronises NUM_REQ asynchronous reset requests into the clk domain.
//   Any request is stretched until HOLD_CYCLES consecutive request-free edges
//   have been seen. The NUM_OUT channel resets are then released one at a time,
//   GAP_CYCLES edges apart, starting with bit 0. A sticky cause register
//   records which request(s) caused a reset.
//
//   Optional build macro: RESET_SEQ_WDT_EN
//     Adds i_wdt_kick and a watchdog that runs only while fully released.
//     A timeout acts as a request and sets o_cause[NUM_REQ].
//     Without the macro there is no i_wdt_kick port and o_cause[NUM_REQ] is 0.
//
// Ports
//   i_clk          sole clock
//   i_reset        synchronous active-high reset
//   i_req_in       asynchronous active-high level requests
//   i_cause_clr    synchronous clear of the cause register
//   i_wdt_kick     watchdog kick (RESET_SEQ_WDT_EN only)
//   o_rst_out      active-high channel resets; bit 0 releases first
//   o_all_released high when every o_rst_out bit is low
//   o_busy         high while any o_rst_out bit is high
//   o_cause        sticky cause bits; bit NUM_REQ is the watchdog bit
module reset_sequencer #(
    parameter int SYNC_STAGES = 3,
    parameter int NUM_REQ     = 2,
    parameter int NUM_OUT     = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int WDT_CYCLES  = 1024
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] i_req_in,
    input  logic               i_cause_clr,
`ifdef RESET_SEQ_WDT_EN
    input  logic               i_wdt_kick,
`endif
    output logic [NUM_OUT-1:0] o_rst_out,
    output logic               o_all_released,
    output logic               o_busy,
    output logic [NUM_REQ:0]   o_cause
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1)  ? $clog2(GAP_CYCLES)  : 1;
    localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0]      GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [NUM_OUT-1:0] ALL_ONES  = '1;
    // Pattern after the first release; zero when there is only one channel.
    localparam logic [NUM_OUT-1:0] FIRST_REL = ALL_ONES << 1;

    typedef enum logic [1:0] {ST_ASSERT, ST_RELEASE, ST_DONE} state_t;

    state_t                              r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0][NUM_REQ-1:0] r_sync;
    logic [HW-1:0]                       r_hold_cnt, w_hold_nxt;
    logic [GW-1:0]                       r_gap_cnt, w_gap_nxt;
    logic [NUM_OUT-1:0]                  r_rst_out, w_rst_nxt, w_shift;
    logic                                r_all_released, r_busy;
    logic [NUM_REQ:0]                    r_cause;
    logic [NUM_REQ-1:0]                  w_req_sync;
    logic                                w_wdt_expire;
    logic                                w_any_req;

    assign w_req_sync = r_sync[SYNC_STAGES-1];
    assign w_any_req  = (|w_req_sync) | w_wdt_expire;
    // Outputs always hold a thermometer pattern (ones at the top), so the
    // next channel release is a left shift; an all-zero result means the
    // last channel is being released.
    assign w_shift    = r_rst_out << 1;

    // Request synchronisers
    always_ff @(posedge i_clk) begin
        if (i_reset) r_sync <= '0;
        else         r_sync <= {r_sync[SYNC_STAGES-2:0], i_req_in};
    end

`ifdef RESET_SEQ_WDT_EN
    localparam int WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

    logic [WW-1:0] r_wdt_cnt;
    logic          r_wdt_expire;

    // Runs only while DONE persists; the expiry pulse comes straight from
    // this flop, with no synchroniser delay.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wdt_cnt    <= '0;
            r_wdt_expire <= 1'b0;
        end else begin
            r_wdt_expire <= 1'b0;
            if (r_state != ST_DONE || w_state_nxt != ST_DONE || i_wdt_kick) begin
                r_wdt_cnt <= '0;
            end else if (r_wdt_cnt == WDT_LAST) begin
                r_wdt_cnt    <= '0;
                r_wdt_expire <= 1'b1;
            end else begin
                r_wdt_cnt <= r_wdt_cnt + 1'b1;
            end
        end
    end

    assign w_wdt_expire = r_wdt_expire;
`else
    // No watchdog in this build; a non-positive timeout is not a legal
    // setting, so this is constant 0 for every legal parameter set.
    assign w_wdt_expire = (WDT_CYCLES < 1);
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_ASSERT;
        else         r_state <= w_state_nxt;
    end

    // Next state; a request always wins over a release due on the same edge
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ASSERT:
                if (!w_any_req && r_hold_cnt == HOLD_LAST)
                    w_state_nxt = (FIRST_REL == '0) ? ST_DONE : ST_RELEASE;
            ST_RELEASE:
                if (w_any_req)
                    w_state_nxt = ST_ASSERT;
                else if (r_gap_cnt == GAP_LAST && w_shift == '0)
                    w_state_nxt = ST_DONE;
            ST_DONE:
                if (w_any_req) w_state_nxt = ST_ASSERT;
            default: w_state_nxt = ST_ASSERT;
        endcase
    end

    // Next values of counters and channel outputs
    always_comb begin
        w_rst_nxt  = r_rst_out;
        w_hold_nxt = r_hold_cnt;
        w_gap_nxt  = r_gap_cnt;
        case (r_state)
            ST_ASSERT: begin
                w_rst_nxt = ALL_ONES;
                if (w_any_req) begin
                    w_hold_nxt = '0;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_rst_nxt  = FIRST_REL;
                    w_hold_nxt = '0;
                    w_gap_nxt  = '0;
                end else begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (w_any_req) begin
                    w_rst_nxt  = ALL_ONES;
                    w_hold_nxt = '0;
                end else if (r_gap_cnt == GAP_LAST) begin
                    w_rst_nxt = w_shift;
                    w_gap_nxt = '0;
                end else begin
                    w_gap_nxt = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_rst_nxt = '0;
                if (w_any_req) begin
                    w_rst_nxt  = ALL_ONES;
                    w_hold_nxt = '0;
                end
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold_cnt     <= '0;
            r_gap_cnt      <= '0;
            r_rst_out      <= ALL_ONES;
            r_all_released <= 1'b0;
            r_busy         <= 1'b1;
            r_cause        <= '0;
        end else begin
            r_hold_cnt     <= w_hold_nxt;
            r_gap_cnt      <= w_gap_nxt;
            r_rst_out      <= w_rst_nxt;
            r_all_released <= (w_rst_nxt == '0);
            r_busy         <= (w_rst_nxt != '0);
            // A set on the same edge as a clear wins
            r_cause        <= (i_cause_clr ? '0 : r_cause) | {w_wdt_expire, w_req_sync};
        end
    end

    assign o_rst_out      = r_rst_out;
    assign o_all_released = r_all_released;
    assign o_busy         = r_busy;
    assign o_cause        = r_cause;

endmodule
